// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the bat_amateur RAM arbiter slice.
package bat_amateur_pkg;

    localparam int BAT_ADDRESS_WIDTH = 16;
    localparam int BAT_DATA_WIDTH    = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACC,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_LDR
    } owner_t;

endpackage

// File: rtl/bat_arb_pick.sv
// Combinational winner selection between CPU and loader.
// Build option: ARB_ROUND_ROBIN_EN selects alternating arbitration instead of
// loader priority with the burst starvation guard.
module bat_arb_pick
    import bat_amateur_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ldr_req,
    input  logic   ldr_lock,
    input  logic   burst_full,
    input  owner_t last_owner,
    output logic   grant,
    output owner_t winner
);

    logic unused_pick;

`ifdef ARB_ROUND_ROBIN_EN
    // Lock and burst state play no part in alternating arbitration.
    assign unused_pick = ldr_lock ^ burst_full;

    // Contention goes to whoever did not win last time.
    always_comb begin
        grant  = cpu_req | ldr_req;
        winner = OWN_LDR;
        if (cpu_req && ldr_req) begin
            winner = (last_owner == OWN_LDR) ? OWN_CPU : OWN_LDR;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end
    end
`else
    // Lock only matters through the burst counter kept by the parent.
    assign unused_pick = ldr_lock ^ (last_owner == OWN_LDR);

    // Loader wins contention unless its locked burst has hit the limit.
    always_comb begin
        grant  = cpu_req | ldr_req;
        winner = OWN_LDR;
        if (cpu_req && (!ldr_req || burst_full)) begin
            winner = OWN_CPU;
        end
    end
`endif

endmodule

// File: rtl/bat_mem_arbiter.sv
// Single-port RAM arbiter between the bat_amateur CPU and the loader/DMA port.
// Every access runs IDLE/RESP (arbitrate) -> ACC (RAM strobe) -> RESP (ack).
// Build option: ARB_ROUND_ROBIN_EN (see bat_arb_pick).
module bat_mem_arbiter
    import bat_amateur_pkg::*;
#(
    parameter int ADDRESS_WIDTH = BAT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = BAT_DATA_WIDTH,
    parameter int MAX_BURST     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CPU_REQ,
    input  logic                     CPU_WE,
    input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
    input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
    output logic                     CPU_ACK,
    output logic [DATA_WIDTH-1:0]    CPU_RDATA,
    output logic                     CPU_STALL,
    input  logic                     LDR_REQ,
    input  logic                     LDR_WE,
    input  logic [ADDRESS_WIDTH-1:0] LDR_ADDR,
    input  logic [DATA_WIDTH-1:0]    LDR_WDATA,
    input  logic                     LDR_LOCK,
    output logic                     LDR_ACK,
    output logic [DATA_WIDTH-1:0]    LDR_RDATA,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0]    RAM_WDATA,
    input  logic [DATA_WIDTH-1:0]    RAM_RDATA
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t              state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  last_owner_q, last_owner_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_rw_q, ram_rw_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    cpu_ack_q, cpu_ack_d;
    logic                    ldr_ack_q, ldr_ack_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                    cpu_stall_q, cpu_stall_d;

    logic   pick_grant;
    owner_t pick_winner;
    logic   burst_full;
    logic   arb_slot;
    logic   take;
    logic   resp_rd;

    assign burst_full = (burst_cnt_q == BURST_LIMIT);
    assign arb_slot   = (state_q != ARB_ACC);
    assign take       = arb_slot & pick_grant;
    assign resp_rd    = (state_q == ARB_RESP) & ~ram_rw_q;

    bat_arb_pick u_pick (
        .cpu_req    (CPU_REQ),
        .ldr_req    (LDR_REQ),
        .ldr_lock   (LDR_LOCK),
        .burst_full (burst_full),
        .last_owner (last_owner_q),
        .grant      (pick_grant),
        .winner     (pick_winner)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: both IDLE and RESP are arbitration slots.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE, ARB_RESP: state_d = pick_grant ? ARB_ACC : ARB_IDLE;
            ARB_ACC:            state_d = ARB_RESP;
            default:            state_d = ARB_IDLE;
        endcase
    end

    // Grant capture, burst tracking, ack generation and read-data capture.
    always_comb begin
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        ram_en_d     = 1'b0;
        ram_rw_d     = ram_rw_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_ack_d    = 1'b0;
        ldr_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;

        if (take) begin
            owner_d      = pick_winner;
            last_owner_d = pick_winner;
            ram_en_d     = 1'b1;
            if (pick_winner == OWN_CPU) begin
                ram_rw_d    = CPU_WE;
                ram_addr_d  = CPU_ADDR;
                ram_wdata_d = CPU_WDATA;
                burst_cnt_d = '0;
            end else begin
                ram_rw_d    = LDR_WE;
                ram_addr_d  = LDR_ADDR;
                ram_wdata_d = LDR_WDATA;
                if (!LDR_LOCK) begin
                    burst_cnt_d = '0;
                end else if (CPU_REQ && !burst_full) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
        end

        if (state_q == ARB_ACC) begin
            cpu_ack_d = (owner_q == OWN_CPU);
            ldr_ack_d = (owner_q == OWN_LDR);
        end

        if (resp_rd) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_d = RAM_RDATA;
            end else begin
                ldr_rdata_d = RAM_RDATA;
            end
        end

        cpu_stall_d = CPU_REQ & ~cpu_ack_d;
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            burst_cnt_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
            cpu_stall_q  <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            ram_en_q     <= ram_en_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
            cpu_stall_q  <= cpu_stall_d;
        end
    end

    // RAM data only arrives in the RESP cycle, so the ack cycle forwards it
    // straight through; the register holds it from the following cycle on.
    assign CPU_RDATA = (resp_rd && owner_q == OWN_CPU) ? RAM_RDATA : cpu_rdata_q;
    assign LDR_RDATA = (resp_rd && owner_q == OWN_LDR) ? RAM_RDATA : ldr_rdata_q;

    assign CPU_ACK   = cpu_ack_q;
    assign LDR_ACK   = ldr_ack_q;
    assign CPU_STALL = cpu_stall_q;
    assign RAM_EN    = ram_en_q;
    assign RAM_RW    = ram_rw_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_bat_mem_arbiter.sv
// Scoreboard bench for bat_mem_arbiter: drivers queue issued transactions,
// a negedge monitor decides grants from the arbitration rules, predicts data
// from a reference memory and checks every RAM strobe, ack, read data and stall.
module tb_bat_mem_arbiter;
    import bat_amateur_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CPU_REQ = 1'b0, CPU_WE = 1'b0;
    logic [AW-1:0] CPU_ADDR = '0;
    logic [DW-1:0] CPU_WDATA = '0;
    logic          CPU_ACK, CPU_STALL;
    logic [DW-1:0] CPU_RDATA;
    logic          LDR_REQ = 1'b0, LDR_WE = 1'b0, LDR_LOCK = 1'b0;
    logic [AW-1:0] LDR_ADDR = '0;
    logic [DW-1:0] LDR_WDATA = '0;
    logic          LDR_ACK;
    logic [DW-1:0] LDR_RDATA;
    logic          RAM_EN, RAM_RW;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [DW-1:0] RAM_RDATA = '0;

    always #5 CLK = ~CLK;

    bat_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA), .CPU_STALL(CPU_STALL),
        .LDR_REQ(LDR_REQ), .LDR_WE(LDR_WE), .LDR_ADDR(LDR_ADDR), .LDR_WDATA(LDR_WDATA),
        .LDR_LOCK(LDR_LOCK), .LDR_ACK(LDR_ACK), .LDR_RDATA(LDR_RDATA),
        .RAM_EN(RAM_EN), .RAM_RW(RAM_RW), .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA),
        .RAM_RDATA(RAM_RDATA)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
    typedef struct { logic we; logic [DW-1:0] rdata; } rsp_t;

    txn_t pend_cpu[$], pend_ldr[$];
    rsp_t rsp_cpu[$], rsp_ldr[$];
    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // RAM: data of a read strobe appears the cycle after RAM_EN; junk otherwise.
    initial begin
        forever begin
            @(posedge CLK);
            if (RAM_EN && RAM_RW) ram_mem[RAM_ADDR] = RAM_WDATA;
            RAM_RDATA <= (RAM_EN && !RAM_RW) ? ram_mem[RAM_ADDR] : DW'($urandom);
        end
    end

    // Reference model state.
    bit            prev_en = 0, prev_rst = 0, cpu_s = 0, ldr_s = 0, lock_s = 0;
    owner_t        prev_win = OWN_CPU, last_win = OWN_CPU;
    int            streak = 0;
    logic [DW-1:0] last_cpu_rd = '0, last_ldr_rd = '0;

    function automatic owner_t model_pick();
        if (!ldr_s) return OWN_CPU;
        if (!cpu_s) return OWN_LDR;
`ifdef ARB_ROUND_ROBIN_EN
        return (last_win == OWN_CPU) ? OWN_LDR : OWN_CPU;
`else
        return (streak >= MB) ? OWN_CPU : OWN_LDR;
`endif
    endfunction

    // Monitor / scoreboard.
    initial begin
        bit   exp_ca, exp_la, exp_en;
        txn_t t;
        rsp_t r;
        owner_t win;
        forever begin
            @(negedge CLK);
            if (prev_rst) begin
                chk("rst_ram_en", 32'(RAM_EN), 0);
                chk("rst_ram_rw", 32'(RAM_RW), 0);
                chk("rst_ram_addr", 32'(RAM_ADDR), 0);
                chk("rst_ram_wdata", 32'(RAM_WDATA), 0);
                chk("rst_cpu_ack", 32'(CPU_ACK), 0);
                chk("rst_ldr_ack", 32'(LDR_ACK), 0);
                chk("rst_cpu_stall", 32'(CPU_STALL), 0);
                chk("rst_cpu_rdata", 32'(CPU_RDATA), 0);
                chk("rst_ldr_rdata", 32'(LDR_RDATA), 0);
                rsp_cpu.delete();
                rsp_ldr.delete();
                streak = 0;
                last_win = OWN_CPU;
                last_cpu_rd = '0;
                last_ldr_rd = '0;
            end else begin
                exp_ca = prev_en && prev_win == OWN_CPU;
                exp_la = prev_en && prev_win == OWN_LDR;
                chk("cpu_ack", 32'(CPU_ACK), 32'(exp_ca));
                chk("ldr_ack", 32'(LDR_ACK), 32'(exp_la));
                if (exp_ca && CPU_ACK) begin
                    chk("cpu_rsp_queued", 32'(rsp_cpu.size() > 0), 1);
                    if (rsp_cpu.size() > 0) begin
                        r = rsp_cpu.pop_front();
                        if (!r.we) last_cpu_rd = r.rdata;
                    end
                end
                if (exp_la && LDR_ACK) begin
                    chk("ldr_rsp_queued", 32'(rsp_ldr.size() > 0), 1);
                    if (rsp_ldr.size() > 0) begin
                        r = rsp_ldr.pop_front();
                        if (!r.we) last_ldr_rd = r.rdata;
                    end
                end
                chk("cpu_rdata", 32'(CPU_RDATA), 32'(last_cpu_rd));
                chk("ldr_rdata", 32'(LDR_RDATA), 32'(last_ldr_rd));
                exp_en = !prev_en && (cpu_s || ldr_s);
                chk("ram_en", 32'(RAM_EN), 32'(exp_en));
                if (RAM_EN && exp_en) begin
                    win = model_pick();
                    prev_win = win;
                    if (win == OWN_CPU) begin
                        chk("cpu_pending", 32'(pend_cpu.size() > 0), 1);
                        t = (pend_cpu.size() > 0) ? pend_cpu.pop_front() : '{1'b0, '0, '0};
                        streak = 0;
                    end else begin
                        chk("ldr_pending", 32'(pend_ldr.size() > 0), 1);
                        t = (pend_ldr.size() > 0) ? pend_ldr.pop_front() : '{1'b0, '0, '0};
                        if (!lock_s) streak = 0;
                        else if (cpu_s) streak++;
                    end
                    last_win = win;
                    chk("ram_addr", 32'(RAM_ADDR), 32'(t.addr));
                    chk("ram_rw", 32'(RAM_RW), 32'(t.we));
                    if (t.we) chk("ram_wdata", 32'(RAM_WDATA), 32'(t.wdata));
                    r.we = t.we;
                    r.rdata = ref_mem[t.addr];
                    if (t.we) ref_mem[t.addr] = t.wdata;
                    if (win == OWN_CPU) rsp_cpu.push_back(r);
                    else rsp_ldr.push_back(r);
                end
                chk("cpu_stall", 32'(CPU_STALL), 32'(cpu_s && !exp_ca));
            end
            prev_en  = RAM_EN;
            prev_rst = RST;
            cpu_s    = CPU_REQ;
            ldr_s    = LDR_REQ;
            lock_s   = LDR_LOCK;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        CPU_WE = we; CPU_ADDR = addr; CPU_WDATA = wd; CPU_REQ = 1'b1;
        pend_cpu.push_back('{we, addr, wd});
    endtask

    task automatic ldr_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic lock);
        LDR_WE = we; LDR_ADDR = addr; LDR_WDATA = wd; LDR_LOCK = lock; LDR_REQ = 1'b1;
        pend_ldr.push_back('{we, addr, wd});
    endtask

    task automatic wait_ack(input bit ldr, output bit ok);
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            cyc();
            ok = ldr ? LDR_ACK : CPU_ACK;
        end
        chk(ldr ? "ldr_ack_seen" : "cpu_ack_seen", 32'(ok), 1);
    endtask

    task automatic wait_ram_en(output bit ok);
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            cyc();
            ok = RAM_EN;
        end
        chk("ram_en_seen", 32'(ok), 1);
    endtask

    task automatic cpu_drv(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            cpu_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            wait_ack(0, ok);
            if (!ok) break;
            if ($urandom_range(0, 1) == 0 || i == n - 1) begin
                CPU_REQ = 1'b0;
                repeat ($urandom_range(0, 3)) cyc();
            end
        end
        CPU_REQ = 1'b0;
    endtask

    task automatic ldr_drv(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ldr_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                      1'($urandom_range(0, 3) != 0));
            wait_ack(1, ok);
            if (!ok) break;
            if ($urandom_range(0, 2) == 0 || i == n - 1) begin
                LDR_REQ = 1'b0;
                repeat ($urandom_range(0, 3)) cyc();
            end
        end
        LDR_REQ = 1'b0;
        LDR_LOCK = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        bit seen;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        repeat (3) cyc();
        RST = 1'b0;
        cyc();

        // CPU read after reset, RAM returns BEEF.
        cpu_issue(1'b0, 16'h0010, '0);
        wait_ack(0, ok);
        chk("t1_rdata", 32'(CPU_RDATA), 32'h0000BEEF);
        CPU_REQ = 1'b0;
        cyc();

        // Loader write and CPU read of the same word raised together.
        ldr_issue(1'b1, 16'h0000, 16'h1234, 1'b0);
        cpu_issue(1'b0, 16'h0000, '0);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            cyc();
            if (LDR_ACK) LDR_REQ = 1'b0;
            seen = CPU_ACK;
        end
        chk("t2_cpu_acked", 32'(seen), 1);
        chk("t2_rdata", 32'(CPU_RDATA), 32'h00001234);
        CPU_REQ = 1'b0;
        cyc();

`ifndef ARB_ROUND_ROBIN_EN
        // Locked loader burst against a waiting CPU.
        cpu_issue(1'b0, 16'h0005, '0);
        ldr_issue(1'b1, 16'h0001, DW'($urandom), 1'b1);
        n = 0;
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            cyc();
            if (LDR_ACK) begin
                n++;
                ldr_issue(1'b1, AW'(n), DW'($urandom), 1'b1);
            end
            if (CPU_ACK) begin
                seen = 1;
                CPU_REQ = 1'b0;
            end
        end
        chk("t3_burst_len", 32'(n), MB);
        chk("t3_cpu_acked", 32'(seen), 1);
        wait_ack(1, ok);
        LDR_REQ = 1'b0;
        LDR_LOCK = 1'b0;
        repeat (2) cyc();
`else
        // Both requesters held: owners must alternate, one ack per 2 cycles.
        cpu_issue(1'b0, 16'h0001, '0);
        ldr_issue(1'b0, 16'h0002, '0, 1'b0);
        n = 0;
        for (int t = 0, k = 0, last = 0, gap = 0; t < 60 && k < 8; t++) begin
            cyc();
            gap++;
            if (CPU_ACK || LDR_ACK) begin
                if (k > 0) begin
                    chk("rr_alternate", 32'(LDR_ACK), 32'(last == 0));
                    chk("rr_gap", 32'(gap), 2);
                end
                last = LDR_ACK;
                gap = 0;
                k++;
                n = k;
                if (CPU_ACK) cpu_issue(1'b0, 16'h0001, '0);
                else ldr_issue(1'b0, 16'h0002, '0, 1'b0);
            end
        end
        chk("rr_acks", 32'(n), 8);
        CPU_REQ = 1'b0;
        LDR_REQ = 1'b0;
        repeat (4) cyc();
        pend_cpu.delete();
        pend_ldr.delete();
`endif

        // Reset during the ACC cycle of a CPU read.
        cpu_issue(1'b0, 16'h0020, '0);
        wait_ram_en(ok);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        CPU_REQ = 1'b0;
        chk("t5_ram_en", 32'(RAM_EN), 0);
        chk("t5_stall", 32'(CPU_STALL), 0);
        n = 0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            n += int'(CPU_ACK);
        end
        chk("t5_no_ack", 32'(n), 0);

        // CPU drops its request in the ACC cycle.
        cpu_issue(1'b1, 16'h0030, 16'hA5A5);
        wait_ram_en(ok);
        CPU_REQ = 1'b0;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            cyc();
            n += int'(CPU_ACK);
        end
        chk("t6_one_ack", 32'(n), 1);

        // Randomized traffic from both ports.
        fork
            cpu_drv(60);
            ldr_drv(80);
        join
        repeat (6) cyc();
        chk("rsp_drained", 32'(rsp_cpu.size() + rsp_ldr.size()), 0);
        chk("pend_drained", 32'(pend_cpu.size() + pend_ldr.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
